// File: rtl/pgm_distributed_sync_fifo_v1_2.sv
// rtl/pgm_distributed_sync_fifo_v1_2.sv - single-clock distributed-RAM FIFO, optional FWFT read path.
// Optional per-word parity protection is enabled by defining PGM_SFIFO_PARITY_EN.
module pgm_distributed_sync_fifo_v1_2 #(
  parameter int ADDR_WIDTH       = 5,
  parameter int DATA_WIDTH       = 32,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 4,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  err_inj,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   water_level,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  parity_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH   = LW'(DEPTH - ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_TH   = LW'(ALMOST_EMPTY_NUM);
`ifdef PGM_SFIFO_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  logic [MEM_W-1:0]    mem_q [DEPTH];
  logic [MEM_W-1:0]    wr_word;
  logic [MEM_W-1:0]    rd_word;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                full_q, full_d;
  logic                afull_q, afull_d;
  logic                empty_q, empty_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, unf_q;
  logic                wr_acc, rd_acc;

  // Acceptance is decided on the registered flags, so limit collisions resolve deterministically.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  assign rd_word = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

`ifdef PGM_SFIFO_PARITY_EN
  logic perr_q;

  assign wr_word = {(^wr_data) ^ err_inj, wr_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= rd_acc & (^rd_word);
    end
  end

  assign parity_err = perr_q;
`else
  logic unused_err_inj;

  assign wr_word        = wr_data;
  assign unused_err_inj = err_inj;
  assign parity_err     = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_acc && !rd_acc) begin
      level_d = level_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      level_d = level_q - 1'b1;
    end
    full_d   = (level_d == DEPTH_L);
    afull_d  = (level_d >= AF_TH);
    empty_d  = (level_d == '0);
    aempty_d = (level_d <= AE_TH);
  end

  // Storage is deliberately left out of reset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= wr_en & full_q;
      unf_q    <= rd_en & empty_q;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = rd_word[DATA_WIDTH-1:0];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q <= '0;
        end else if (rd_acc) begin
          rd_data_q <= rd_word[DATA_WIDTH-1:0];
        end
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign water_level  = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_pgm_distributed_sync_fifo_v1_2.sv
// tb/tb_pgm_distributed_sync_fifo_v1_2.sv - self-checking bench for pgm_distributed_sync_fifo_v1_2.
module tb_pgm_distributed_sync_fifo_v1_2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_inj = 1'b0;
  logic [31:0] wr_data = '0;

  logic        a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf, a_perr;
  logic [31:0] a_rd_data;
  logic [4:0]  a_level;
  logic        b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf, b_perr;
  logic [31:0] b_rd_data;
  logic [4:0]  b_level;

  always #5 clk = ~clk;

  pgm_distributed_sync_fifo_v1_2 #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .err_inj(err_inj),
    .full(a_full), .almost_full(a_afull), .rd_en(rd_en), .rd_data(a_rd_data),
    .empty(a_empty), .almost_empty(a_aempty), .water_level(a_level),
    .overflow(a_ovf), .underflow(a_unf), .parity_err(a_perr)
  );

  pgm_distributed_sync_fifo_v1_2 #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .err_inj(err_inj),
    .full(b_full), .almost_full(b_afull), .rd_en(rd_en), .rd_data(b_rd_data),
    .empty(b_empty), .almost_empty(b_aempty), .water_level(b_level),
    .overflow(b_ovf), .underflow(b_unf), .parity_err(b_perr)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    int          exp_level;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t        vecs [34];
  logic [31:0] m_q [$];
  logic        m_inj [$];
  logic [31:0] sb_q [$];
  logic        sb_perr [$];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] d,
                              input int lvl, input logic o, input logic u);
    vec_t v;
    v.wr = w; v.rd = r; v.wdata = d; v.exp_level = lvl; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a plain queue decides acceptance from its own occupancy.
  task automatic step(input logic w, input logic r, input logic [31:0] d, input logic inj);
    int          sz;
    logic        wacc, racc, eovf, eunf, eperr;
    logic [31:0] exp_rd;
    sz   = m_q.size();
    wacc = w && (sz < 16);
    racc = r && (sz > 0);
    eovf = w && (sz == 16);
    eunf = r && (sz == 0);
    if (racc) begin
      sb_q.push_back(m_q.pop_front());
      sb_perr.push_back(m_inj.pop_front());
    end
    if (wacc) begin
      m_q.push_back(d);
      m_inj.push_back(inj);
    end
    wr_en = w; rd_en = r; wr_data = d; err_inj = inj;
    @(posedge clk);
    #1;
    sz = m_q.size();
    chk("level", 64'(a_level), 64'(sz));
    chk("full", 64'(a_full), 64'(sz == 16));
    chk("almost_full", 64'(a_afull), 64'(sz >= 12));
    chk("empty", 64'(a_empty), 64'(sz == 0));
    chk("almost_empty", 64'(a_aempty), 64'(sz <= 4));
    chk("overflow", 64'(a_ovf), 64'(eovf));
    chk("underflow", 64'(a_unf), 64'(eunf));
    chk("fwft_level", 64'(b_level), 64'(sz));
    eperr = 1'b0;
    if (racc) begin
      exp_rd = sb_q.pop_front();
      eperr  = sb_perr.pop_front();
      chk("rd_data", 64'(a_rd_data), 64'(exp_rd));
    end
`ifndef PGM_SFIFO_PARITY_EN
    eperr = 1'b0;
`endif
    chk("parity_err", 64'(a_perr), 64'(eperr));
    chk("fwft_parity_err", 64'(b_perr), 64'(eperr));
    if (sz > 0) chk("fwft_rd_data", 64'(b_rd_data), 64'(m_q[0]));
    wr_en = 1'b0; rd_en = 1'b0; err_inj = 1'b0;
  endtask

  task automatic do_reset(input logic w);
    rst = 1'b1; wr_en = w; rd_en = 1'b0; wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0;
    m_q.delete(); m_inj.delete(); sb_q.delete(); sb_perr.delete();
    chk("rst_level", 64'(a_level), 64'd0);
    chk("rst_empty", 64'(a_empty), 64'd1);
    chk("rst_almost_empty", 64'(a_aempty), 64'd1);
    chk("rst_full", 64'(a_full), 64'd0);
    chk("rst_almost_full", 64'(a_afull), 64'd0);
    chk("rst_overflow", 64'(a_ovf), 64'd0);
    chk("rst_underflow", 64'(a_unf), 64'd0);
    chk("rst_parity_err", 64'(a_perr), 64'd0);
    chk("rst_rd_data", 64'(a_rd_data), 64'd0);
    chk("rst_fwft_empty", 64'(b_empty), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) vecs[i] = mk(1'b1, 1'b0, 32'(i), i + 1, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'd99, 16, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) vecs[17 + k] = mk(1'b0, 1'b1, 32'd0, 15 - k, 1'b0, 1'b0);
    vecs[33] = mk(1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b1);

    @(negedge clk);
    do_reset(1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);

    // Fill to full, reject one write, drain to empty, reject one read.
    for (int i = 0; i < 34; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].wdata, 1'b0);
      chk("vec_level", 64'(a_level), 64'(vecs[i].exp_level));
      chk("vec_overflow", 64'(a_ovf), 64'(vecs[i].exp_ovf));
      chk("vec_underflow", 64'(a_unf), 64'(vecs[i].exp_unf));
    end

    step(1'b1, 1'b0, 32'hA5A5_0001, 1'b0);
    chk("fwft_word_visible", 64'(b_rd_data), 64'hA5A5_0001);
    chk("fwft_not_empty", 64'(b_empty), 64'd0);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    chk("fwft_empty_after_read", 64'(b_empty), 64'd1);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(100 + i), 1'b0);
    step(1'b1, 1'b1, 32'h0BAD, 1'b0);
    chk("full_rw_level", 64'(a_level), 64'd15);
    chk("full_rw_overflow", 64'(a_ovf), 64'd1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h55, 1'b0);
    chk("empty_rw_level", 64'(a_level), 64'd1);
    chk("empty_rw_underflow", 64'(a_unf), 64'd1);

    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'(200 + i), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 32'(1000 + i), 1'b0);
    chk("stream_level", 64'(a_level), 64'd8);

    step(1'b1, 1'b0, 32'h0999, 1'b0);
    do_reset(1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'h77, 1'b0);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    chk("post_reset_word", 64'(a_rd_data), 64'h77);

    step(1'b1, 1'b0, 32'h1234, 1'b1);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    chk("parity_rd_data", 64'(a_rd_data), 64'h1234);
    step(1'b1, 1'b0, 32'h0005, 1'b0);
    step(1'b0, 1'b1, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
